// File: rtl/idex_hazard_reg_if.sv
// Decode-to-execute bus: ID_* fields flow into the pipeline register, IDEX_* fields
// flow out to the EX-stage forwarding unit and ALU.
interface idex_hazard_reg_if #(
  parameter int DW = 16,
  parameter int RW = 4,
  parameter int AW = 4
);
  logic          ID_valid;
  logic [DW-1:0] ID_op1, ID_op2;
  logic [RW-1:0] ID_rs1, ID_rs2, ID_rd;
  logic          ID_use1, ID_use2;
  logic          ID_regwrite, ID_memread, ID_memwrite, ID_memtoreg;
  logic [AW-1:0] ID_aluop;

  logic          IDEX_valid, IDEX_regwrite, IDEX_memread, IDEX_memwrite, IDEX_memtoreg;
  logic [DW-1:0] IDEX_op1, IDEX_op2;
  logic [RW-1:0] IDEX_rs1, IDEX_rs2, IDEX_rd;
  logic [AW-1:0] IDEX_aluop;

  modport master (
    output ID_valid, ID_op1, ID_op2, ID_rs1, ID_rs2, ID_rd, ID_use1, ID_use2,
           ID_regwrite, ID_memread, ID_memwrite, ID_memtoreg, ID_aluop,
    input  IDEX_valid, IDEX_regwrite, IDEX_memread, IDEX_memwrite, IDEX_memtoreg,
           IDEX_op1, IDEX_op2, IDEX_rs1, IDEX_rs2, IDEX_rd, IDEX_aluop
  );

  modport slave (
    input  ID_valid, ID_op1, ID_op2, ID_rs1, ID_rs2, ID_rd, ID_use1, ID_use2,
           ID_regwrite, ID_memread, ID_memwrite, ID_memtoreg, ID_aluop,
    output IDEX_valid, IDEX_regwrite, IDEX_memread, IDEX_memwrite, IDEX_memtoreg,
           IDEX_op1, IDEX_op2, IDEX_rs1, IDEX_rs2, IDEX_rd, IDEX_aluop
  );
endinterface

// File: rtl/idex_hazard_reg.sv
// ID/EX pipeline register with load-use bubble insertion, EX hold and branch flush,
// plus a saturating count of inserted load-use bubbles.
module idex_hazard_reg #(
  parameter int DW = 16,
  parameter int RW = 4,
  parameter int AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  idex_hazard_reg_if.slave   bus,
  input  logic               ex_busy,
  input  logic               flush,
  output logic               stall,
  output logic [15:0]        bubble_cnt
);

  typedef struct packed {
    logic          valid;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
    logic          memtoreg;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [RW-1:0] rd;
    logic [AW-1:0] aluop;
  } idex_t;

  idex_t       idex_q, idex_d, id_word;
  logic [15:0] cnt_q, cnt_d;
  logic        hz;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    idex_d = idex_q;
    cnt_d  = cnt_q;

    id_word = '{valid:    bus.ID_valid,
                regwrite: bus.ID_regwrite,
                memread:  bus.ID_memread,
                memwrite: bus.ID_memwrite,
                memtoreg: bus.ID_memtoreg,
                op1:      bus.ID_op1,
                op2:      bus.ID_op2,
                rs1:      bus.ID_rs1,
                rs2:      bus.ID_rs2,
                rd:       bus.ID_rd,
                aluop:    bus.ID_aluop};

    // R0 is never a real load destination, so it can never create a hazard.
    hz = idex_q.valid & idex_q.memread & (idex_q.rd != '0) & bus.ID_valid &
         ((bus.ID_use1 & (bus.ID_rs1 == idex_q.rd)) |
          (bus.ID_use2 & (bus.ID_rs2 == idex_q.rd)));

    stall = ~flush & (ex_busy | hz);

    // An all-zero bubble keeps rd=0 so the forwarding unit never matches it.
    if (flush) begin
      idex_d = '0;
    end else if (ex_busy) begin
      idex_d = idex_q;
    end else if (hz) begin
      idex_d = '0;
      cnt_d  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    end else begin
      idex_d = id_word;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idex_q <= '0;
      cnt_q  <= '0;
    end else begin
      idex_q <= idex_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.IDEX_valid    = idex_q.valid;
  assign bus.IDEX_regwrite = idex_q.regwrite;
  assign bus.IDEX_memread  = idex_q.memread;
  assign bus.IDEX_memwrite = idex_q.memwrite;
  assign bus.IDEX_memtoreg = idex_q.memtoreg;
  assign bus.IDEX_op1      = idex_q.op1;
  assign bus.IDEX_op2      = idex_q.op2;
  assign bus.IDEX_rs1      = idex_q.rs1;
  assign bus.IDEX_rs2      = idex_q.rs2;
  assign bus.IDEX_rd       = idex_q.rd;
  assign bus.IDEX_aluop    = idex_q.aluop;
  assign bubble_cnt        = cnt_q;

endmodule

// File: tb/tb_idex_hazard_reg.sv
// Directed bench for idex_hazard_reg: reset, pass-through, load-use, hold, flush,
// reset during stall and bubble counter saturation.
module tb_idex_hazard_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_busy;
  logic        flush;
  logic        stall;
  logic [15:0] bubble_cnt;
  int          vectors = 0;
  int          miscompares = 0;

  idex_hazard_reg_if bus ();

  idex_hazard_reg dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .ex_busy    (ex_busy),
    .flush      (flush),
    .stall      (stall),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [15:0] o1, input logic [15:0] o2,
                           input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] rd,
                           input logic u1, input logic u2, input logic rw, input logic mr,
                           input logic [3:0] op);
    bus.ID_valid    = v;
    bus.ID_op1      = o1;
    bus.ID_op2      = o2;
    bus.ID_rs1      = r1;
    bus.ID_rs2      = r2;
    bus.ID_rd       = rd;
    bus.ID_use1     = u1;
    bus.ID_use2     = u2;
    bus.ID_regwrite = rw;
    bus.ID_memread  = mr;
    bus.ID_memwrite = 1'b0;
    bus.ID_memtoreg = mr;
    bus.ID_aluop    = op;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; ex_busy = 1'b0; flush = 1'b0;
    set_instr(1, 16'hDEAD, 16'hCAFE, 4'd7, 4'd8, 4'd9, 1, 1, 1, 1, 4'hF);
    bus.ID_memwrite = 1'b1;
    step();
    vectors++;
    if ({bus.IDEX_valid, bus.IDEX_regwrite, bus.IDEX_memread, bus.IDEX_memwrite,
         bus.IDEX_memtoreg, bus.IDEX_op1, bus.IDEX_op2, bus.IDEX_rs1, bus.IDEX_rs2,
         bus.IDEX_rd, bus.IDEX_aluop} !== '0) begin
      miscompares++; $display("FAIL reset_idex: nonzero IDEX outputs op1=%h op2=%h rd=%h", bus.IDEX_op1, bus.IDEX_op2, bus.IDEX_rd);
    end
    vectors++;
    if (bubble_cnt !== 16'h0) begin miscompares++; $display("FAIL reset_cnt: got %h want 0000", bubble_cnt); end
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", stall); end
    rst = 1'b1;
  endtask

  task automatic test_pass_through();
    set_instr(1, 16'h1234, 16'hBEEF, 4'd1, 4'd2, 4'd3, 1, 1, 1, 0, 4'h2);
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL pass_stall: got %b want 0", stall); end
    step();
    vectors++;
    if (bus.IDEX_op2 !== 16'hBEEF) begin miscompares++; $display("FAIL pass_op2: got %h want beef", bus.IDEX_op2); end
    vectors++;
    if (bus.IDEX_op1 !== 16'h1234) begin miscompares++; $display("FAIL pass_op1: got %h want 1234", bus.IDEX_op1); end
    vectors++;
    if ({bus.IDEX_valid, bus.IDEX_regwrite, bus.IDEX_memread, bus.IDEX_rd, bus.IDEX_rs1, bus.IDEX_rs2, bus.IDEX_aluop}
        !== {1'b1, 1'b1, 1'b0, 4'd3, 4'd1, 4'd2, 4'h2}) begin
      miscompares++; $display("FAIL pass_ctrl: valid=%b rw=%b mr=%b rd=%h rs1=%h rs2=%h alu=%h want 1 1 0 3 1 2 2",
        bus.IDEX_valid, bus.IDEX_regwrite, bus.IDEX_memread, bus.IDEX_rd, bus.IDEX_rs1, bus.IDEX_rs2, bus.IDEX_aluop);
    end
    // Invalid slot is still captured, only valid is low.
    set_instr(0, 16'h5555, 16'h6666, 4'd4, 4'd5, 4'd6, 0, 0, 1, 0, 4'h1);
    step();
    vectors++;
    if ({bus.IDEX_valid, bus.IDEX_regwrite, bus.IDEX_op2, bus.IDEX_rd} !== {1'b0, 1'b1, 16'h6666, 4'd6}) begin
      miscompares++; $display("FAIL pass_invalid: valid=%b rw=%b op2=%h rd=%h want 0 1 6666 6",
        bus.IDEX_valid, bus.IDEX_regwrite, bus.IDEX_op2, bus.IDEX_rd);
    end
  endtask

  task automatic test_load_use();
    set_instr(1, 16'h0100, 16'h0000, 4'd1, 4'd0, 4'd5, 1, 0, 1, 1, 4'h0);
    step();
    set_instr(1, 16'h0222, 16'hAAAA, 4'd6, 4'd5, 4'd7, 1, 1, 1, 0, 4'h3);
    vectors++;
    if (stall !== 1'b1) begin miscompares++; $display("FAIL lu_stall: got %b want 1", stall); end
    step();
    vectors++;
    if ({bus.IDEX_valid, bus.IDEX_memread, bus.IDEX_rd, bus.IDEX_op2} !== {1'b0, 1'b0, 4'd0, 16'h0}) begin
      miscompares++; $display("FAIL lu_bubble: valid=%b mr=%b rd=%h op2=%h want 0 0 0 0000",
        bus.IDEX_valid, bus.IDEX_memread, bus.IDEX_rd, bus.IDEX_op2);
    end
    vectors++;
    if (bubble_cnt !== 16'd1) begin miscompares++; $display("FAIL lu_cnt: got %h want 0001", bubble_cnt); end
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL lu_stall_clear: got %b want 0", stall); end
    step();
    vectors++;
    if ({bus.IDEX_valid, bus.IDEX_rd, bus.IDEX_op2, bus.IDEX_aluop} !== {1'b1, 4'd7, 16'hAAAA, 4'h3}) begin
      miscompares++; $display("FAIL lu_dep: valid=%b rd=%h op2=%h alu=%h want 1 7 aaaa 3",
        bus.IDEX_valid, bus.IDEX_rd, bus.IDEX_op2, bus.IDEX_aluop);
    end
    // Load to R0 never stalls.
    set_instr(1, 16'h0000, 16'h0000, 4'd1, 4'd0, 4'd0, 1, 0, 1, 1, 4'h0);
    step();
    set_instr(1, 16'h0333, 16'h0444, 4'd0, 4'd0, 4'd8, 1, 1, 1, 0, 4'h4);
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL lu_r0_stall: got %b want 0", stall); end
    // Matching index with its use flag low never stalls either.
    set_instr(1, 16'h0000, 16'h0000, 4'd1, 4'd0, 4'd5, 1, 0, 1, 1, 4'h0);
    step();
    set_instr(1, 16'h0555, 16'h0666, 4'd5, 4'd5, 4'd9, 0, 0, 1, 0, 4'h5);
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL lu_nouse_stall: got %b want 0", stall); end
    step();
    vectors++;
    if ({bus.IDEX_valid, bus.IDEX_rd, bubble_cnt} !== {1'b1, 4'd9, 16'd1}) begin
      miscompares++; $display("FAIL lu_nouse_load: valid=%b rd=%h cnt=%h want 1 9 0001", bus.IDEX_valid, bus.IDEX_rd, bubble_cnt);
    end
  endtask

  task automatic test_hold();
    set_instr(1, 16'h1111, 16'h2222, 4'd2, 4'd3, 4'd9, 1, 1, 1, 0, 4'h6);
    step();
    ex_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_instr(1, 16'h2000 + 16'(i), 16'h3000 + 16'(i), 4'd1, 4'd1, 4'(i + 1), 1, 1, 0, 1, 4'h7);
      vectors++;
      if (stall !== 1'b1) begin miscompares++; $display("FAIL hold_stall[%0d]: got %b want 1", i, stall); end
      step();
      vectors++;
      if ({bus.IDEX_valid, bus.IDEX_op1, bus.IDEX_op2, bus.IDEX_rd, bus.IDEX_memread, bus.IDEX_aluop}
          !== {1'b1, 16'h1111, 16'h2222, 4'd9, 1'b0, 4'h6}) begin
        miscompares++; $display("FAIL hold_regs[%0d]: op1=%h op2=%h rd=%h mr=%b alu=%h want 1111 2222 9 0 6",
          i, bus.IDEX_op1, bus.IDEX_op2, bus.IDEX_rd, bus.IDEX_memread, bus.IDEX_aluop);
      end
    end
    ex_busy = 1'b0;
    set_instr(1, 16'h3333, 16'h4444, 4'd4, 4'd4, 4'd10, 1, 1, 1, 0, 4'h8);
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL hold_release_stall: got %b want 0", stall); end
    step();
    vectors++;
    if ({bus.IDEX_op1, bus.IDEX_rd} !== {16'h3333, 4'd10}) begin
      miscompares++; $display("FAIL hold_resume: op1=%h rd=%h want 3333 a", bus.IDEX_op1, bus.IDEX_rd);
    end
  endtask

  task automatic test_flush_priority();
    set_instr(1, 16'h0000, 16'h0000, 4'd1, 4'd0, 4'd5, 1, 0, 1, 1, 4'h0);
    step();
    set_instr(1, 16'h7777, 16'h8888, 4'd5, 4'd2, 4'd11, 1, 1, 1, 0, 4'h9);
    ex_busy = 1'b1;
    flush   = 1'b1;
    #1;
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL flush_stall: got %b want 0", stall); end
    step();
    vectors++;
    if ({bus.IDEX_valid, bus.IDEX_memread, bus.IDEX_regwrite, bus.IDEX_rd, bus.IDEX_op1, bus.IDEX_aluop}
        !== {1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 4'h0}) begin
      miscompares++; $display("FAIL flush_bubble: valid=%b mr=%b rw=%b rd=%h op1=%h alu=%h want all 0",
        bus.IDEX_valid, bus.IDEX_memread, bus.IDEX_regwrite, bus.IDEX_rd, bus.IDEX_op1, bus.IDEX_aluop);
    end
    vectors++;
    if (bubble_cnt !== 16'd1) begin miscompares++; $display("FAIL flush_cnt: got %h want 0001", bubble_cnt); end
    ex_busy = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    set_instr(1, 16'h0000, 16'h0000, 4'd1, 4'd0, 4'd5, 1, 0, 1, 1, 4'h0);
    step();
    set_instr(1, 16'h0999, 16'h0AAA, 4'd5, 4'd0, 4'd12, 1, 0, 1, 0, 4'h1);
    vectors++;
    if (stall !== 1'b1) begin miscompares++; $display("FAIL rst_mid_pre_stall: got %b want 1", stall); end
    rst = 1'b0;
    step();
    vectors++;
    if ({bus.IDEX_valid, bus.IDEX_memread, bus.IDEX_rd, bubble_cnt, stall} !== {1'b0, 1'b0, 4'd0, 16'd0, 1'b0}) begin
      miscompares++; $display("FAIL rst_mid: valid=%b mr=%b rd=%h cnt=%h stall=%b want 0 0 0 0000 0",
        bus.IDEX_valid, bus.IDEX_memread, bus.IDEX_rd, bubble_cnt, stall);
    end
    rst = 1'b1;
  endtask

  task automatic test_saturation();
    logic [15:0] exp_cnt [3];
    exp_cnt[0] = 16'hFFFE;
    exp_cnt[1] = 16'hFFFF;
    exp_cnt[2] = 16'hFFFF;
    set_instr(0, 16'h0000, 16'h0000, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 4'h0);
    force dut.cnt_q = 16'hFFFD;
    step();
    release dut.cnt_q;
    #1;
    vectors++;
    if (bubble_cnt !== 16'hFFFD) begin miscompares++; $display("FAIL sat_preload: got %h want fffd", bubble_cnt); end
    for (int i = 0; i < 3; i++) begin
      set_instr(1, 16'h0000, 16'h0000, 4'd1, 4'd0, 4'd6, 1, 0, 1, 1, 4'h0);
      step();
      set_instr(1, 16'h0000, 16'h0000, 4'd6, 4'd0, 4'd2, 1, 0, 1, 0, 4'h2);
      step();
      vectors++;
      if (bubble_cnt !== exp_cnt[i]) begin
        miscompares++; $display("FAIL sat_cnt[%0d]: got %h want %h", i, bubble_cnt, exp_cnt[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_load_use();
    test_hold();
    test_flush_priority();
    test_reset_mid_stall();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
